liteic_slave_rr_arbiter: RTL and testbench

Round-robin transaction scheduler for one interconnect slave node's read path. It shares the single downstream AXI-Lite slave between up to N_REQ crossbar master slots, one outstanding read at a time. It replaces the fixed-priority master selection so that no master slot can starve. It sits between the node's per-master AR valid vector and its AR/R steering muxes. It owns which master is granted and for how long, while the node keeps the datapath muxing.

---
 rtl/liteic_pkg.sv | 15 +
 rtl/liteic_rr_pick.sv | 34 +++
 rtl/liteic_slave_rr_arbiter.sv | 85 ++++++++
 tb/tb_liteic_slave_rr_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/liteic_pkg.sv
// Shared types and helpers for the liteic interconnect slave node.
package liteic_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  // Index width for n master slots; a single slot still gets a 1-bit id.
  function automatic int arb_id_width(int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/liteic_rr_pick.sv
// Combinational rotate-priority pick: first set request at or above ptr, wrapping to 0.
module liteic_rr_pick #(
  parameter int N_REQ    = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [N_REQ-1:0]    req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [N_REQ-1:0]    onehot,
  output logic [ID_WIDTH-1:0] id,
  output logic                any_valid
);

  logic [N_REQ-1:0] upper_req;
  logic [N_REQ-1:0] sel_req;

  // Requests at or above ptr win; if none, the lowest request overall is the wrapped winner.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_upper
      assign upper_req[gi] = req[gi] & (gi >= int'(ptr));
    end
  endgenerate

  assign sel_req   = (|upper_req) ? upper_req : req;
  assign onehot    = sel_req & (~sel_req + N_REQ'(1));
  assign any_valid = |req;

  always_comb begin
    id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (onehot[i]) id = id | ID_WIDTH'(i);
    end
  end

endmodule

// File: rtl/liteic_slave_rr_arbiter.sv
// Round-robin owner of a slave node's read path: one outstanding AR/R transaction at a time.
module liteic_slave_rr_arbiter
  import liteic_pkg::*;
#(
  parameter int  N_REQ    = 4,
  localparam int ID_WIDTH = arb_id_width(N_REQ)
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [N_REQ-1:0]    req_i,
  input  logic                addr_hs_i,
  input  logic                resp_hs_i,
  output logic [N_REQ-1:0]    gnt_onehot_o,
  output logic [ID_WIDTH-1:0] gnt_id_o,
  output logic                addr_phase_o,
  output logic                busy_o
);

  arb_state_t          state_reg;
  logic [ID_WIDTH-1:0] ptr_reg;
  logic [ID_WIDTH-1:0] ptr_next;
  logic [ID_WIDTH-1:0] pick_ptr;
  logic [N_REQ-1:0]    pick_onehot;
  logic [ID_WIDTH-1:0] pick_id;
  logic                pick_valid;

  assign ptr_next = (gnt_id_o == ID_WIDTH'(N_REQ - 1)) ? '0 : gnt_id_o + ID_WIDTH'(1);

  // In RESP the pick must already see the post-completion pointer for back-to-back grants.
  assign pick_ptr = (state_reg == ARB_RESP) ? ptr_next : ptr_reg;

  liteic_rr_pick #(
    .N_REQ    (N_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req       (req_i),
    .ptr       (pick_ptr),
    .onehot    (pick_onehot),
    .id        (pick_id),
    .any_valid (pick_valid)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg    <= ARB_IDLE;
      ptr_reg      <= '0;
      gnt_onehot_o <= '0;
      gnt_id_o     <= '0;
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          if (pick_valid) begin
            gnt_onehot_o <= pick_onehot;
            gnt_id_o     <= pick_id;
            state_reg    <= ARB_ADDR;
          end
        end
        ARB_ADDR: begin
          if (addr_hs_i) state_reg <= ARB_RESP;
        end
        ARB_RESP: begin
          if (resp_hs_i) begin
            ptr_reg <= ptr_next;
            if (pick_valid) begin
              gnt_onehot_o <= pick_onehot;
              gnt_id_o     <= pick_id;
              state_reg    <= ARB_ADDR;
            end else begin
              gnt_onehot_o <= '0;
              state_reg    <= ARB_IDLE;
            end
          end
        end
        default: begin
          gnt_onehot_o <= '0;
          state_reg    <= ARB_IDLE;
        end
      endcase
    end
  end

  assign addr_phase_o = (state_reg == ARB_ADDR);
  assign busy_o       = (state_reg != ARB_IDLE);

endmodule

// File: tb/tb_liteic_slave_rr_arbiter.sv
// Directed and randomized checks of the round-robin read arbiter against a behavioural model.
module tb_liteic_slave_rr_arbiter;

  localparam int N = 4;

  logic         clk_i = 1'b0;
  logic         rstn_i;
  logic [N-1:0] req_i;
  logic         addr_hs_i;
  logic         resp_hs_i;
  logic [N-1:0] gnt_onehot_o;
  logic [1:0]   gnt_id_o;
  logic         addr_phase_o;
  logic         busy_o;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  // Behavioural model: phase 0 = no owner, 1 = address, 2 = response.
  int m_phase;
  int m_ptr;
  int m_gnt;

  liteic_slave_rr_arbiter #(.N_REQ(N)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .req_i        (req_i),
    .addr_hs_i    (addr_hs_i),
    .resp_hs_i    (resp_hs_i),
    .gnt_onehot_o (gnt_onehot_o),
    .gnt_id_o     (gnt_id_o),
    .addr_phase_o (addr_phase_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int rr_pick(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_ptr   = 0;
    m_gnt   = 0;
  endtask

  task automatic model_step(logic [N-1:0] r, logic a, logic s);
    int g;
    if (m_phase == 0) begin
      g = rr_pick(r, m_ptr);
      if (g >= 0) begin
        m_gnt   = g;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (a) m_phase = 2;
    end else if (s) begin
      m_ptr = (m_gnt + 1) % N;
      g = rr_pick(r, m_ptr);
      if (g >= 0) begin
        m_gnt   = g;
        m_phase = 1;
      end else begin
        m_phase = 0;
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [N-1:0] exp_oh;
    exp_oh = (m_phase != 0) ? N'(1 << m_gnt) : '0;
    chk("model_onehot", 32'(gnt_onehot_o), 32'(exp_oh));
    chk("model_id", 32'(gnt_id_o), 32'(m_gnt));
    chk("model_addr_phase", 32'(addr_phase_o), 32'(m_phase == 1));
    chk("model_busy", 32'(busy_o), 32'(m_phase != 0));
  endtask

  task automatic cyc(logic [N-1:0] r, logic a, logic s);
    req_i     = r;
    addr_hs_i = a;
    resp_hs_i = s;
    @(posedge clk_i);
    model_step(r, a, s);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    req_i     = '0;
    addr_hs_i = 1'b0;
    resp_hs_i = 1'b0;
    rstn_i    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_onehot", 32'(gnt_onehot_o), 32'd0);
    chk("rst_id", 32'(gnt_id_o), 32'd0);
    chk("rst_addr_phase", 32'(addr_phase_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    rstn_i = 1'b1;
  endtask

  int order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    do_reset();

    // Single request from reset, then full transaction leaving ptr at 3.
    cyc(4'b0100, 1'b0, 1'b0);
    chk("first_onehot", 32'(gnt_onehot_o), 32'h4);
    chk("first_id", 32'(gnt_id_o), 32'd2);
    chk("first_addr_phase", 32'(addr_phase_o), 32'd1);
    cyc(4'b0100, 1'b1, 1'b0);
    chk("after_ar_addr_phase", 32'(addr_phase_o), 32'd0);
    chk("after_ar_busy", 32'(busy_o), 32'd1);
    cyc(4'b0000, 1'b0, 1'b1);
    chk("after_r_busy", 32'(busy_o), 32'd0);

    // ptr = 3 with slots 0 and 1 requesting: wrap to 0, then 1 back-to-back.
    cyc(4'b0011, 1'b0, 1'b0);
    chk("wrap_first_id", 32'(gnt_id_o), 32'd0);
    cyc(4'b0011, 1'b1, 1'b0);
    cyc(4'b0011, 1'b0, 1'b1);
    chk("wrap_second_id", 32'(gnt_id_o), 32'd1);
    chk("wrap_second_addr_phase", 32'(addr_phase_o), 32'd1);
    cyc(4'b0011, 1'b1, 1'b0);
    cyc(4'b0000, 1'b0, 1'b1);

    // Grant 1 is held while requests change and stray handshakes arrive.
    cyc(4'b0010, 1'b0, 1'b0);
    chk("hold_grant_id", 32'(gnt_id_o), 32'd1);
    cyc(4'b1000, 1'b0, 1'b0);
    cyc(4'b1000, 1'b0, 1'b1);
    chk("stray_r_onehot", 32'(gnt_onehot_o), 32'h2);
    chk("stray_r_addr_phase", 32'(addr_phase_o), 32'd1);
    cyc(4'b1000, 1'b1, 1'b1);
    chk("both_hs_busy", 32'(busy_o), 32'd1);
    chk("both_hs_addr_phase", 32'(addr_phase_o), 32'd0);
    cyc(4'b1000, 1'b1, 1'b0);
    chk("stray_ar_onehot", 32'(gnt_onehot_o), 32'h2);
    chk("stray_ar_busy", 32'(busy_o), 32'd1);
    cyc(4'b1000, 1'b0, 1'b1);
    chk("handover_id", 32'(gnt_id_o), 32'd3);
    cyc(4'b0000, 1'b1, 1'b0);
    cyc(4'b0000, 1'b0, 1'b1);

    // All slots requesting for 8 transactions: strict rotation, no idle gap.
    do_reset();
    cyc(4'b1111, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      chk("rr_order_id", 32'(gnt_id_o), 32'(order[k]));
      chk("rr_order_addr_phase", 32'(addr_phase_o), 32'd1);
      cyc(4'b1111, 1'b1, 1'b0);
      cyc(4'b1111, 1'b0, 1'b1);
    end
    cyc(4'b0000, 1'b1, 1'b0);
    cyc(4'b0000, 1'b0, 1'b1);

    // Asynchronous reset in the response phase, then ptr restarts at 0.
    cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b0100, 1'b1, 1'b0);
    #2;
    rstn_i = 1'b0;
    model_reset();
    #1;
    chk("async_rst_onehot", 32'(gnt_onehot_o), 32'd0);
    chk("async_rst_busy", 32'(busy_o), 32'd0);
    chk("async_rst_addr_phase", 32'(addr_phase_o), 32'd0);
    chk("async_rst_id", 32'(gnt_id_o), 32'd0);
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    cyc(4'b0010, 1'b0, 1'b0);
    chk("post_rst_id", 32'(gnt_id_o), 32'd1);
    cyc(4'b0010, 1'b1, 1'b0);
    cyc(4'b0000, 1'b0, 1'b1);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      cyc(N'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
